acc_core: RTL
=============

ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of accumulator, registers, memory data and address (legal 8..32).
REQ-002 SHALL have parameter IMM_W, default 5: immediate/register-index width; register file depth = 2**IMM_W.
REQ-003 SHALL fix opcode width at 3; instruction = low (3+IMM_W) bits of the fetched word, opcode = MSB 3 bits of that field, imm = low IMM_W bits.
REQ-004 Ports, clock and reset first:
 clk  in  1  sole clock, all state changes on rising edge
 reset  in  1  synchronous, active-high reset
 mem_req  out  1  memory transfer request
 mem_we  out  1  1 = write, 0 = read; valid while mem_req high
 mem_addr  out  DATA_W  transfer address
 mem_wdata  out  DATA_W  write data
 mem_rdata  in  DATA_W  read data, sampled on the completing edge
 mem_ack  in  1  transfer completes on an edge where mem_req and mem_ack are both high
 pc  out  DATA_W  current program counter
 acc_out  out  DATA_W  accumulator
 carry  out  1  carry/borrow flag
 zero  out  1  accumulator-zero flag
 halted  out  1  core stopped

Function
REQ-005 FSM states SHALL be FETCH, EXEC, MEM, HALT.
REQ-006 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on ack, latch instr and set pc<=pc+1 mod 2**DATA_W, then go to EXEC.
REQ-007 EXEC: execute the decoded instruction in one cycle; LW/SW go to MEM, halt goes to HALT, all others go to FETCH.
REQ-008 Opcodes: 000 LDI acc<=sign-extend(imm); 001 LDR acc<=R[imm]; 010 STR R[imm]<=acc; 011 ADD acc<=acc+R[imm]; 100 SUB acc<=acc-R[imm]; 101 LW R[imm]<=mem[acc]; 110 SW mem[acc]<=R[imm]; 111 BRZ: if zero then pc<=R[imm].
REQ-009 Opcode 111 with imm all-ones SHALL be HALT regardless of zero.
REQ-010 ADD: carry = carry-out of the DATA_W+1-bit sum; SUB: carry = 1 when acc < R[imm] unsigned (borrow); other ops leave carry unchanged.
REQ-011 zero SHALL equal (acc==0) after every write to acc and SHALL be held otherwise.
REQ-012 MEM: mem_req=1, mem_addr=acc, mem_we=1 for SW with mem_wdata=R[imm]; on ack, LW writes mem_rdata to R[imm]; then go to FETCH.
REQ-013 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the completing edge; ack while mem_req=0 SHALL be ignored.
REQ-014 Zero-wait latency: ALU/branch ops 2 cycles, LW/SW 3 cycles; each ack-wait cycle adds 1.
REQ-015 pc 2**DATA_W-1 SHALL wrap to 0; branch target is R[imm] directly.
REQ-016 HALT: mem_req=0, halted=1, no state change until reset.
REQ-017 At most one transfer outstanding; mem_req=0 in EXEC and HALT.

Reset
REQ-018 reset SHALL, at the next edge and from any state including mid-transfer: state=FETCH, pc=0, acc=0, carry=0, zero=1, halted=0, all R cleared, instr cleared.
REQ-019 During and in the cycle after reset, mem_req SHALL be 0 in the reset cycle; a pending ack in that cycle SHALL be discarded.

Structure
REQ-020 Shared package acc_core_pkg SHALL hold the opcode constants, the HALT encoding and the state enumeration.
REQ-021 The register file SHALL be sub-module acc_core_regfile (1 read, 1 write port, synchronous write, combinational read, synchronous clear).

Verification
REQ-022 DATA_W=8: LDI imm=5'b11101 -> acc_out=0xFD, zero=0, carry unchanged.
REQ-023 acc=0xFF, R[1]=0x01, ADD 1 -> acc_out=0x00, carry=1, zero=1; then SUB 1 -> acc_out=0xFF, carry=1.
REQ-024 LW with ack delayed 3 cycles -> address/we stable all 4 req cycles, R[imm]=mem_rdata, 6 cycles total.
REQ-025 zero=1, R[2]=0x40, BRZ 2 -> next fetch address 0x40; zero=0 -> next fetch pc+1; pc=0xFF fetch -> pc=0x00.
REQ-026 Fetch of 0xFF -> halted=1, mem_req=0 for 20 cycles; reset -> pc=0, fetch resumes at 0.
REQ-027 reset asserted during MEM wait of an SW with ack same cycle -> no register update, state FETCH, pc=0.

Source files
------------

// File: rtl/acc_core_pkg.sv
// Shared definitions for the accumulator core: opcodes, halt encoding, FSM states.
package acc_core_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_LDI = 3'b000;
  localparam logic [OPC_W-1:0] OP_LDR = 3'b001;
  localparam logic [OPC_W-1:0] OP_STR = 3'b010;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b011;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b100;
  localparam logic [OPC_W-1:0] OP_LW  = 3'b101;
  localparam logic [OPC_W-1:0] OP_SW  = 3'b110;
  localparam logic [OPC_W-1:0] OP_BRZ = 3'b111;

  // Halt shares the branch opcode and is selected by an all-ones immediate.
  localparam logic [OPC_W-1:0] OP_HALT = OP_BRZ;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  function automatic logic is_halt(input logic [OPC_W-1:0] op, input logic imm_all_ones);
    return (op == OP_HALT) && imm_all_ones;
  endfunction

endpackage

// File: rtl/acc_core_regfile.sv
// General-purpose register file: one combinational read port, one synchronous write port.
module acc_core_regfile
  import acc_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IMM_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IMM_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**IMM_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/acc_core.sv
// Multi-cycle accumulator CPU: FETCH -> EXEC -> (MEM) over a single req/ack memory port.
module acc_core
  import acc_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] acc_out,
  output logic              carry,
  output logic              zero,
  output logic              halted
);

  localparam int INSTR_W = OPC_W + IMM_W;

  state_t             state;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  acc;
  logic [OPC_W-1:0]   opcode;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  rf_rdata;
  logic [DATA_W-1:0]  rf_wdata;
  logic               rf_we;
  logic [DATA_W-1:0]  acc_nxt;
  logic               carry_nxt;
  logic               acc_wr;

  function automatic logic [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] v);
    return DATA_W'(v);
  endfunction

  assign opcode  = instr[INSTR_W-1 -: OPC_W];
  assign imm     = instr[IMM_W-1:0];
  assign acc_out = acc;

  // Request is gated by reset so an ack arriving in the reset cycle cannot complete anything.
  assign mem_req   = !reset && ((state == ST_FETCH) || (state == ST_MEM));
  assign mem_we    = (state == ST_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state == ST_MEM) ? acc : pc;
  assign mem_wdata = (state == ST_MEM) ? rf_rdata : '0;

  always_comb begin
    acc_nxt   = acc;
    carry_nxt = carry;
    acc_wr    = 1'b0;
    case (opcode)
      OP_LDI: begin
        acc_nxt = sext_imm(imm);
        acc_wr  = 1'b1;
      end
      OP_LDR: begin
        acc_nxt = rf_rdata;
        acc_wr  = 1'b1;
      end
      OP_ADD: begin
        {carry_nxt, acc_nxt} = {1'b0, acc} + {1'b0, rf_rdata};
        acc_wr = 1'b1;
      end
      OP_SUB: begin
        acc_nxt   = acc - rf_rdata;
        carry_nxt = (acc < rf_rdata);
        acc_wr    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = acc;
    if (!reset) begin
      if ((state == ST_EXEC) && (opcode == OP_STR)) rf_we = 1'b1;
      if ((state == ST_MEM) && (opcode == OP_LW) && mem_ack) begin
        rf_we    = 1'b1;
        rf_wdata = mem_rdata;
      end
    end
  end

  acc_core_regfile #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_regfile (
    .clk   (clk),
    .clr   (reset),
    .we    (rf_we),
    .waddr (imm),
    .wdata (rf_wdata),
    .raddr (imm),
    .rdata (rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      pc     <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
      halted <= 1'b0;
      instr  <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ack) begin
            instr <= mem_rdata[INSTR_W-1:0];
            pc    <= pc + DATA_W'(1);
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          carry <= carry_nxt;
          if (acc_wr) begin
            acc  <= acc_nxt;
            zero <= (acc_nxt == '0);
          end
          if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            state <= ST_MEM;
          end else if (opcode == OP_BRZ) begin
            if (is_halt(opcode, &imm)) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else if (zero) begin
              pc <= rf_rdata;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack) state <= ST_FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule
